vga_plot_scheduler: RTL and testbench
=====================================

Name: vga_plot_scheduler

Overview:
- Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between NUM_REQ rectangle requesters, for example tank, gun, bullet and border drawers.
- Round-robin arbiter plus rectangle-fill sequencer: the winner's rectangle is latched and emitted one pixel per clock.
- Replaces the hand-coded per-sprite erase/draw states in the game FSM; the game FSM only posts requests and waits for done.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- COORD_W, 8, width of x/y coordinates.
- DIM_W, 5, width of rectangle width/height fields (max 31 px).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester draw request; level, held until that requester's done.
- req_x  in  NUM_REQ*COORD_W  top-left x; requester i at slice [i*COORD_W +: COORD_W].
- req_y  in  NUM_REQ*COORD_W  top-left y; same slicing.
- req_w  in  NUM_REQ*DIM_W  rectangle width in pixels.
- req_h  in  NUM_REQ*DIM_W  rectangle height in pixels.
- req_colour  in  NUM_REQ*3  fill colour; black = erase.
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse when a request is accepted.
- done  out  NUM_REQ  one-hot, 1-cycle pulse when that rectangle is finished.
- busy  out  1  high in DRAW and DONE.
- x  out  COORD_W  pixel x to the adapter.
- y  out  COORD_W  pixel y to the adapter.
- colour  out  3  pixel colour.
- plot  out  1  pixel write enable.

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - gnt, done, busy, x, y, colour, plot all go to 0.
  - Round-robin pointer last set to NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-draw abandons the rectangle; no done pulse is issued.
- All outputs are registered.
- State IDLE:
  - If req != 0, the winner is the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - On that edge:
    - gnt[winner]=1 for one cycle; last=winner.
    - The winner's x, y, w, h and colour are latched; cx=cy=0.
    - Go to DRAW, or to DONE if w==0 or h==0.
  - If req==0, stay in IDLE.
- State DRAW, at each edge:
  - x=x0+cx and y=y0+cy, both truncated modulo 2^COORD_W; colour=latched colour; plot=1.
  - Then cx increments. When cx==w-1, cx=0 and cy increments.
  - After the pixel (w-1, h-1) is emitted, go to DONE.
  - Exactly w*h plot cycles, raster order, row-major, no gaps.
  - The first plot cycle is the cycle after the gnt cycle.
- State DONE:
  - plot=0; done[winner]=1 for one cycle; go to IDLE.
  - Arbitration happens on the next edge, so gap between back-to-back rectangles is 2 idle plot cycles.
- Request rules:
  - Request fields are sampled only at grant; later changes are ignored.
  - Deasserting req while granted does not abort the draw.
  - A requester still asserting req after its done is re-served only when round-robin reaches it again.
- Starvation bound: any held request is granted within NUM_REQ-1 other rectangles.
- Simultaneous events: the req bit of the current owner is ignored while busy.

Optional Feature:
- Macro CLIP_EN.
- Defined:
  - During DRAW, if x0+cx, computed at COORD_W+1 bits, is ≥160, or y0+cy is ≥120, then plot=0 for that cycle.
  - The cycle is still consumed, so timing is unchanged at w*h cycles.
  - x/y are still driven with the truncated values.
- Undefined: plot=1 on every DRAW cycle; coordinates wrap modulo 2^COORD_W.

Test Plan:
1. req[0] with x=144, y=50, w=16, h=8, colour=3'b011 -> gnt[0] one cycle, then 128 consecutive plot cycles, first (144,50), 16th (159,50), last (159,57), then done[0] one cycle and busy=0 after it.
2. req=4'b1111 held, each w=2, h=1 -> grant order 0,1,2,3,0,1; each rectangle 2 plot cycles; 4 cycles gnt-to-gnt.
3. req[2] with w=0, h=5 -> gnt[2], zero plot cycles, done[2] on the next cycle.
4. Start req[1] with w=4, h=4; assert resetn=0 after the 6th pixel -> plot=0, busy=0 and gnt=done=0 immediately, and done[1] never pulses. After release, req=4'b0011 -> gnt[0] first.
5. After gnt[3], change req_x[3] and req_colour[3] -> emitted pixels keep the originally latched values.
6. x=155, y=10, w=8, h=1 -> 8 DRAW cycles and done after the 8th. With CLIP_EN, plot is high on 5 cycles (x=155..159). Without it, plot is high on all 8 (x up to 162).

Source files
------------

// File: rtl/vga_plot_scheduler.sv
// vga_plot_scheduler: round-robin arbiter and rectangle-fill sequencer for the VGA pixel port.
// Optional `define CLIP_EN: suppress plot for pixels outside the 160x120 visible area.
module vga_plot_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int COORD_W = 8,
  parameter int DIM_W   = 5
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  input  logic [NUM_REQ*DIM_W-1:0]   req_w,
  input  logic [NUM_REQ*DIM_W-1:0]   req_h,
  input  logic [NUM_REQ*3-1:0]       req_colour,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [COORD_W-1:0]         x,
  output logic [COORD_W-1:0]         y,
  output logic [2:0]                 colour,
  output logic                       plot
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state, state_d;
  logic [IW-1:0] last, win, idx;
  logic [IW:0] sum;
  logic [COORD_W-1:0] x0, y0, x_nxt, y_nxt, x_d, y_d;
  logic [DIM_W-1:0] w, h, cx, cy, w_sel, h_sel;
  logic [2:0] col, colour_d;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic any_req, start, row_end, last_px, in_view, busy_d, plot_d;
  // Scan from farthest to nearest so the candidate closest after last wins.
  always_comb begin
    win = '0;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, last} + (IW+1)'(k);
      idx = sum >= (IW+1)'(NUM_REQ) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
      win = req[idx] ? idx : win;
    end
  end
  assign any_req = |req;
  assign start   = state == IDLE && any_req;
  assign w_sel   = req_w[win*DIM_W +: DIM_W];
  assign h_sel   = req_h[win*DIM_W +: DIM_W];
  assign row_end = cx == w - DIM_W'(1);
  assign last_px = row_end && cy == h - DIM_W'(1);
`ifdef CLIP_EN
  logic [COORD_W:0] px, py;
  assign px      = {1'b0, x0} + (COORD_W+1)'(cx);
  assign py      = {1'b0, y0} + (COORD_W+1)'(cy);
  assign in_view = px < (COORD_W+1)'(160) && py < (COORD_W+1)'(120);
  assign x_nxt   = px[COORD_W-1:0];
  assign y_nxt   = py[COORD_W-1:0];
`else
  assign in_view = 1'b1;
  assign x_nxt   = x0 + COORD_W'(cx);
  assign y_nxt   = y0 + COORD_W'(cy);
`endif
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state == IDLE ? (any_req ? ((w_sel == '0 || h_sel == '0) ? DONE : DRAW) : IDLE) :
              state == DRAW ? (last_px ? DONE : DRAW) : IDLE;
  end
  always_comb begin
    gnt_d    = start ? NUM_REQ'(1) << win : '0;
    done_d   = state == DONE ? NUM_REQ'(1) << last : '0;
    busy_d   = state_d != IDLE;
    plot_d   = state == DRAW && in_view;
    x_d      = state == DRAW ? x_nxt : x;
    y_d      = state == DRAW ? y_nxt : y;
    colour_d = state == DRAW ? col : colour;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      last   <= IW'(NUM_REQ - 1);
      x0     <= '0;
      y0     <= '0;
      w      <= '0;
      h      <= '0;
      col    <= '0;
      cx     <= '0;
      cy     <= '0;
    end else begin
      gnt    <= gnt_d;
      done   <= done_d;
      busy   <= busy_d;
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
      plot   <= plot_d;
      if (start) begin
        last <= win;
        x0   <= req_x[win*COORD_W +: COORD_W];
        y0   <= req_y[win*COORD_W +: COORD_W];
        w    <= w_sel;
        h    <= h_sel;
        col  <= req_colour[win*3 +: 3];
        cx   <= '0;
        cy   <= '0;
      end else if (state == DRAW) begin
        cx <= row_end ? '0 : cx + DIM_W'(1);
        cy <= row_end ? cy + DIM_W'(1) : cy;
      end
    end
  end
endmodule

// File: tb/tb_vga_plot_scheduler.sv
// tb_vga_plot_scheduler: randomized and directed checks of vga_plot_scheduler against a raster/round-robin model.
module tb_vga_plot_scheduler;
  localparam int N = 4, CW = 8, DW = 5;
  logic clock = 1'b0;
  logic resetn;
  logic [N-1:0] req;
  logic [N*CW-1:0] req_x, req_y;
  logic [N*DW-1:0] req_w, req_h;
  logic [N*3-1:0] req_colour;
  logic [N-1:0] gnt, done;
  logic busy, plot;
  logic [CW-1:0] x, y;
  logic [2:0] colour;
  int checks = 0, passes = 0;
  int gnt_glitch, busy_low;
  logic [2*CW+3:0] cap[$];
  int rx[N], ry[N], rw[N], rh[N], rc[N];

  vga_plot_scheduler #(.NUM_REQ(N), .COORD_W(CW), .DIM_W(DW)) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .gnt(gnt), .done(done),
    .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot));

  always #5 clock = ~clock;

  function automatic logic [2*CW+3:0] model_px(int x0, int y0, int w, int c, int k);
    int ax, ay;
    logic p;
    ax = x0 + k % w;
    ay = y0 + k / w;
`ifdef CLIP_EN
    p = ax < 160 && ay < 120;
`else
    p = 1'b1;
`endif
    return {p, 3'(c), CW'(ay), CW'(ax)};
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == N'(1) << i) return i;
    return -2;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic post(int i, int x0, int y0, int w, int h, int c);
    req_x[i*CW +: CW] = CW'(x0);
    req_y[i*CW +: CW] = CW'(y0);
    req_w[i*DW +: DW] = DW'(w);
    req_h[i*DW +: DW] = DW'(h);
    req_colour[i*3 +: 3] = 3'(c);
    req[i] = 1'b1;
  endtask

  task automatic rand_post(int i);
    rx[i] = $urandom_range(0, 255);
    ry[i] = $urandom_range(0, 255);
    rw[i] = $urandom_range(0, 5);
    rh[i] = $urandom_range(0, 4);
    rc[i] = $urandom_range(0, 7);
    post(i, rx[i], ry[i], rw[i], rh[i], rc[i]);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req = '0;
    repeat (2) step();
    resetn = 1'b1;
  endtask

  task automatic wait_gnt(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int t = 0; t < 200 && who == -1; t++) begin
      step();
      cyc++;
      if (gnt != '0) who = onehot_idx(gnt);
    end
  endtask

  task automatic collect(output int who, output int ncyc);
    cap.delete();
    gnt_glitch = 0;
    busy_low = 0;
    who = -1;
    for (int t = 0; t < 3000 && who == -1; t++) begin
      step();
      if (done != '0) who = onehot_idx(done);
      else begin
        cap.push_back({plot, colour, y, x});
        if (gnt != '0) gnt_glitch++;
        if (!busy) busy_low++;
      end
    end
    ncyc = cap.size();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req = '0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (2) step();
    checks++; if ({gnt, done, busy, x, y, colour, plot} !== '0) $display("FAIL reset_outputs got %h exp 0", {gnt, done, busy, x, y, colour, plot}); else passes++;
    resetn = 1'b1;
    repeat (2) step();
    checks++; if ({gnt, done, busy, plot} !== '0) $display("FAIL idle_no_req got %h exp 0", {gnt, done, busy, plot}); else passes++;
  endtask

  task automatic test_single_rect();
    int who, cyc, dw, n, nbad;
    post(0, 144, 50, 16, 8, 3);
    wait_gnt(who, cyc);
    checks++; if (who !== 0) $display("FAIL single_gnt got %0d exp 0", who); else passes++;
    collect(dw, n);
    req[0] = 1'b0;
    checks++; if (n !== 128) $display("FAIL single_count got %0d exp 128", n); else passes++;
    checks++; if (cap[0][15:0] !== {8'd50, 8'd144}) $display("FAIL single_first got %h exp %h", cap[0][15:0], {8'd50, 8'd144}); else passes++;
    checks++; if (cap[15][15:0] !== {8'd50, 8'd159}) $display("FAIL single_16th got %h exp %h", cap[15][15:0], {8'd50, 8'd159}); else passes++;
    checks++; if (cap[127][15:0] !== {8'd57, 8'd159}) $display("FAIL single_last got %h exp %h", cap[127][15:0], {8'd57, 8'd159}); else passes++;
    nbad = 0;
    for (int k = 0; k < 128; k++) if (cap[k] !== model_px(144, 50, 16, 3, k)) nbad++;
    checks++; if (nbad !== 0) $display("FAIL single_stream got %0d bad pixels exp 0", nbad); else passes++;
    checks++; if (gnt_glitch !== 0 || busy_low !== 0) $display("FAIL single_gnt_busy got gnt_extra=%0d busy_low=%0d exp 0", gnt_glitch, busy_low); else passes++;
    checks++; if (dw !== 0) $display("FAIL single_done got %0d exp 0", dw); else passes++;
    step();
    checks++; if ({busy, done} !== '0) $display("FAIL single_after got %h exp 0", {busy, done}); else passes++;
  endtask

  task automatic test_round_robin();
    int who, cyc, dw, n;
    do_reset();
    for (int i = 0; i < N; i++) post(i, 10 * i, 5, 2, 1, i + 1);
    for (int r = 0; r < 6; r++) begin
      wait_gnt(who, cyc);
      checks++; if (who !== r % N || cyc !== 1) $display("FAIL rr_gnt%0d got idx=%0d gap=%0d exp idx=%0d gap=1", r, who, cyc, r % N); else passes++;
      collect(dw, n);
      checks++; if (dw !== r % N || n !== 2) $display("FAIL rr_rect%0d got done=%0d plots=%0d exp done=%0d plots=2", r, dw, n, r % N); else passes++;
    end
    req = '0;
    step();
  endtask

  task automatic test_zero_size();
    int who, cyc, dw, n;
    post(2, 10, 10, 0, 5, 1);
    wait_gnt(who, cyc);
    checks++; if (who !== 2) $display("FAIL zero_gnt got %0d exp 2", who); else passes++;
    collect(dw, n);
    req[2] = 1'b0;
    checks++; if (dw !== 2 || n !== 0) $display("FAIL zero_done got done=%0d cycles=%0d exp done=2 cycles=0", dw, n); else passes++;
    step();
  endtask

  task automatic test_reset_mid_draw();
    int who, cyc, dw, n, stray;
    post(1, 20, 20, 4, 4, 5);
    wait_gnt(who, cyc);
    checks++; if (who !== 1) $display("FAIL midrst_gnt got %0d exp 1", who); else passes++;
    repeat (6) step();
    resetn = 1'b0;
    #1;
    checks++; if ({plot, busy, gnt, done} !== '0) $display("FAIL midrst_async got %h exp 0", {plot, busy, gnt, done}); else passes++;
    post(0, 1, 1, 1, 1, 2);
    stray = 0;
    repeat (3) begin step(); if (done != '0) stray++; end
    resetn = 1'b1;
    wait_gnt(who, cyc);
    checks++; if (who !== 0 || stray !== 0) $display("FAIL midrst_regnt got idx=%0d stray_done=%0d exp idx=0 stray_done=0", who, stray); else passes++;
    collect(dw, n);
    req[0] = 1'b0;
    wait_gnt(who, cyc);
    collect(dw, n);
    req[1] = 1'b0;
    checks++; if (who !== 1 || dw !== 1 || n !== 16) $display("FAIL midrst_redo got gnt=%0d done=%0d plots=%0d exp 1 1 16", who, dw, n); else passes++;
    step();
  endtask

  task automatic test_latch();
    int who, cyc, dw, n, nbad;
    post(3, 30, 40, 3, 2, 6);
    wait_gnt(who, cyc);
    req_x[3*CW +: CW] = 8'd99;
    req_colour[3*3 +: 3] = 3'd1;
    req_y[3*CW +: CW] = 8'd7;
    collect(dw, n);
    req[3] = 1'b0;
    nbad = 0;
    for (int k = 0; k < 6; k++) if (cap[k] !== model_px(30, 40, 3, 6, k)) nbad++;
    checks++; if (who !== 3 || n !== 6 || nbad !== 0) $display("FAIL latch got gnt=%0d plots=%0d bad=%0d exp 3 6 0", who, n, nbad); else passes++;
    step();
  endtask

  task automatic test_clip_edge();
    int who, cyc, dw, n, nbad, nplot, eplot;
    post(0, 155, 10, 8, 1, 7);
    wait_gnt(who, cyc);
    collect(dw, n);
    req[0] = 1'b0;
    nbad = 0;
    nplot = 0;
    for (int k = 0; k < n; k++) nplot += int'(cap[k][2*CW+3]);
    for (int k = 0; k < 8; k++) if (cap[k] !== model_px(155, 10, 8, 7, k)) nbad++;
`ifdef CLIP_EN
    eplot = 5;
`else
    eplot = 8;
`endif
    checks++; if (n !== 8 || dw !== 0) $display("FAIL edge_timing got cycles=%0d done=%0d exp 8 0", n, dw); else passes++;
    checks++; if (nplot !== eplot) $display("FAIL edge_plots got %0d exp %0d", nplot, eplot); else passes++;
    checks++; if (nbad !== 0) $display("FAIL edge_stream got %0d bad exp 0", nbad); else passes++;
    step();
  endtask

  task automatic test_random();
    int who, cyc, dw, n, nbad, exp, exp_last;
    do_reset();
    exp_last = N - 1;
    for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) rand_post(i);
    for (int r = 0; r < 30; r++) begin
      if (req == '0) rand_post($urandom_range(0, N - 1));
      exp = -1;
      for (int k = 1; k <= N; k++) if (exp < 0 && req[(exp_last + k) % N]) exp = (exp_last + k) % N;
      wait_gnt(who, cyc);
      checks++; if (who !== exp) $display("FAIL rand_gnt%0d got %0d exp %0d", r, who, exp); else passes++;
      exp_last = exp;
      if ($urandom_range(0, 3) == 0) req[exp] = 1'b0;
      collect(dw, n);
      req[exp] = 1'b0;
      nbad = 0;
      for (int k = 0; k < rw[exp] * rh[exp]; k++) if (cap[k] !== model_px(rx[exp], ry[exp], rw[exp], rc[exp], k)) nbad++;
      checks++; if (dw !== exp || n !== rw[exp] * rh[exp] || nbad !== 0) $display("FAIL rand_rect%0d got done=%0d plots=%0d bad=%0d exp done=%0d plots=%0d bad=0", r, dw, n, nbad, exp, rw[exp] * rh[exp]); else passes++;
      for (int i = 0; i < N; i++) if (!req[i] && $urandom_range(0, 2) == 0) rand_post(i);
    end
    req = '0;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_single_rect();
    test_round_robin();
    test_zero_size();
    test_reset_mid_draw();
    test_latch();
    test_clip_edge();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
